// File: rtl/fetch_pc_unit.sv
// Program counter and fetch stage: drives the word address into instruction memory and
// registers the returned word, with branch redirect/squash, stall and halt handling.
module fetch_pc_unit #(
    parameter int unsigned        BITSIZE  = 32,
    parameter int unsigned        REGSIZE  = 64,
    parameter int unsigned        MEMDEPTH = 64,
    parameter logic [REGSIZE-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Stall,
    input  logic               Halt,
    input  logic               BranchTaken,
    input  logic [REGSIZE-1:0] BranchOffset,
    input  logic [BITSIZE-1:0] InstrIn,
    output logic [REGSIZE-1:0] InstrAddress,
    output logic [REGSIZE-1:0] PC,
    output logic [BITSIZE-1:0] Instruction,
    output logic [REGSIZE-1:0] InstrPC,
    output logic               InstrValid,
    output logic               Halted
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    localparam logic [REGSIZE-1:0] MemDepthW = REGSIZE'(MEMDEPTH);
    localparam logic [REGSIZE-1:0] PcStep    = REGSIZE'(4);

    logic [1:0]         state_q, state_d;
    logic [REGSIZE-1:0] pc_q, pc_d;
    logic [REGSIZE-1:0] instr_pc_q, instr_pc_d;
    logic [BITSIZE-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic [REGSIZE-1:0] word_idx;
    logic [REGSIZE-1:0] br_target;
    logic               out_of_range;
    logic               unused_offset_top;

    assign word_idx     = {2'b00, pc_q[REGSIZE-1:2]};
    assign out_of_range = (word_idx >= MemDepthW);
    // Word offset to bytes; the top two offset bits fall off the shift.
    assign br_target    = instr_pc_q + {BranchOffset[REGSIZE-3:0], 2'b00};
    assign unused_offset_top = ^BranchOffset[REGSIZE-1:REGSIZE-2];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        case (state_q)
            StIdle: begin
                state_d = StRun;
            end
            StRun: begin
                if (Halt || out_of_range) begin
                    state_d = StHalted;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    instr_d    = InstrIn;
                    instr_pc_d = pc_q;
                    // A branch only counts when it comes from a real instruction.
                    if (BranchTaken && valid_q) begin
                        pc_d    = br_target;
                        valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + PcStep;
                        valid_d = 1'b1;
                    end
                end
            end
            StHalted: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_pc_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign InstrAddress = word_idx;
    assign PC           = pc_q;
    assign Instruction  = instr_q;
    assign InstrPC      = instr_pc_q;
    assign InstrValid   = valid_q;
    assign Halted       = (state_q == StHalted);

endmodule
